// File: rtl/eth_mac_filter_pkg.sv
// Package for the Ethernet AXI-Stream destination-MAC filter.
// Holds REG_BUS register offsets, mode bit positions, the filter FSM state
// enum, the destination MAC length and the accept-rule helper.
// The optional statistics counters are controlled by MAC_FILTER_STATS_EN
// (see eth_mac_filter_regs).
package eth_mac_filter_pkg;

  localparam int MAC_BYTES   = 6;
  localparam int PROMISC_BIT = 16;
  localparam int MCAST_BIT   = 17;

  localparam logic [3:0] REG_MAC_LO = 4'h0;
  localparam logic [3:0] REG_MAC_HI = 4'h4;
  localparam logic [3:0] REG_PASS   = 4'h8;
  localparam logic [3:0] REG_DROP   = 4'hC;

  typedef enum logic [1:0] {
    HDR    = 2'd0,
    REPLAY = 2'd1,
    PASS   = 2'd2,
    DROP   = 2'd3
  } state_t;

  // dest/mac are packed with wire byte i at [8i+7:8i]; the multicast flag is
  // therefore bit 0 of wire byte 0.
  function automatic logic mac_accept(input logic [47:0] dest,
                                      input logic [47:0] mac,
                                      input logic        promisc,
                                      input logic        mcast_en);
    return promisc || (dest == mac) || (dest == '1) || (mcast_en && dest[0]);
  endfunction

endpackage

// File: rtl/eth_mac_filter_regs.sv
// REG_BUS slave for the MAC filter: station MAC, mode bits and statistics.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reg_addr/write/wdata/wstrb/valid  request (byte address)
//   reg_rdata/error/ready    same-cycle response (ready = valid)
//   inc_pass, inc_drop       one-cycle pulses from the filter FSM
//   mac, promisc, mcast_en   current filter configuration
// Optional macro MAC_FILTER_STATS_EN: when defined, 0x8/0xC are saturating
// passed/dropped frame counters (a write to either clears both); when
// undefined they read 0 and ignore writes.
module eth_mac_filter_regs
  import eth_mac_filter_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int REG_DW = 32,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_AW-1:0]   reg_addr,
  input  logic                reg_write,
  input  logic [REG_DW-1:0]   reg_wdata,
  input  logic [REG_DW/8-1:0] reg_wstrb,
  input  logic                reg_valid,
  output logic [REG_DW-1:0]   reg_rdata,
  output logic                reg_error,
  output logic                reg_ready,
  input  logic                inc_pass,
  input  logic                inc_drop,
  output logic [47:0]         mac,
  output logic                promisc,
  output logic                mcast_en
);

  logic aligned;
  logic wr_lo;
  logic wr_hi;

  // An exact offset match implies addr[1:0] == 0, so misaligned writes
  // never reach any register.
  assign aligned   = (reg_addr[1:0] == 2'b00);
  assign reg_ready = reg_valid;
  assign reg_error = reg_valid && !aligned;
  assign wr_lo     = reg_valid && reg_write && (reg_addr == REG_AW'(REG_MAC_LO));
  assign wr_hi     = reg_valid && reg_write && (reg_addr == REG_AW'(REG_MAC_HI));

  always_ff @(posedge clk) begin
    if (rst) begin
      mac      <= '0;
      promisc  <= 1'b0;
      mcast_en <= 1'b0;
    end else begin
      if (wr_lo) begin
        for (int b = 0; b < 4; b++) begin
          if (reg_wstrb[b]) mac[8*b +: 8] <= reg_wdata[8*b +: 8];
        end
      end
      if (wr_hi) begin
        if (reg_wstrb[0]) mac[39:32] <= reg_wdata[7:0];
        if (reg_wstrb[1]) mac[47:40] <= reg_wdata[15:8];
        if (reg_wstrb[2]) begin
          promisc  <= reg_wdata[PROMISC_BIT];
          mcast_en <= reg_wdata[MCAST_BIT];
        end
      end
    end
  end

`ifdef MAC_FILTER_STATS_EN
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             clr;
  logic             unused_bits;

  assign clr = reg_valid && reg_write &&
               ((reg_addr == REG_AW'(REG_PASS)) || (reg_addr == REG_AW'(REG_DROP)));

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (inc_pass && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
      if (inc_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign unused_bits = ^{reg_wdata[REG_DW-1:MCAST_BIT+1], reg_wstrb[3]};
`else
  logic unused_bits;
  assign unused_bits = ^{reg_wdata[REG_DW-1:MCAST_BIT+1], reg_wstrb[3],
                         inc_pass, inc_drop};
`endif

  always_comb begin
    reg_rdata = '0;
    if (aligned) begin
      if (reg_addr == REG_AW'(REG_MAC_LO)) begin
        reg_rdata = mac[31:0];
      end else if (reg_addr == REG_AW'(REG_MAC_HI)) begin
        reg_rdata[15:0]        = mac[47:32];
        reg_rdata[PROMISC_BIT] = promisc;
        reg_rdata[MCAST_BIT]   = mcast_en;
`ifdef MAC_FILTER_STATS_EN
      end else if (reg_addr == REG_AW'(REG_PASS)) begin
        reg_rdata = REG_DW'(pass_cnt);
      end else if (reg_addr == REG_AW'(REG_DROP)) begin
        reg_rdata = REG_DW'(drop_cnt);
`endif
      end
    end
  end

endmodule

// File: rtl/eth_axis_mac_filter.sv
// Byte-wide AXI-Stream Ethernet destination-MAC filter.
// Buffers the 6 destination MAC bytes, decides accept/reject on the 6th
// byte, then replays the header and feeds the rest through (accept) or
// swallows the frame (reject). Runt frames (tlast before byte 6) are dropped.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   s_axis_*                 input stream (tdata[7:0], tvalid, tready, tlast, tuser)
//   m_axis_*                 output stream (same fields)
//   reg_*                    REG_BUS slave (see eth_mac_filter_regs)
//   dbg_state                current FSM state
// Valid/ready: a beat transfers on a rising edge where tvalid && tready; once
// m_axis_tvalid is raised its payload holds until that transfer.
// Optional macro MAC_FILTER_STATS_EN enables the frame counters at 0x8/0xC.
module eth_axis_mac_filter
  import eth_mac_filter_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int REG_DW = 32,
  parameter int CNT_W  = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7:0]          s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser,
  output logic [7:0]          m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  input  logic [REG_AW-1:0]   reg_addr,
  input  logic                reg_write,
  input  logic [REG_DW-1:0]   reg_wdata,
  input  logic [REG_DW/8-1:0] reg_wstrb,
  input  logic                reg_valid,
  output logic [REG_DW-1:0]   reg_rdata,
  output logic                reg_error,
  output logic                reg_ready,
  output state_t              dbg_state
);

  localparam logic [2:0] LAST_IDX = 3'(MAC_BYTES - 1);

  state_t      state;
  logic [7:0]  hdr_data [MAC_BYTES];
  logic        hdr_last [MAC_BYTES];
  logic        hdr_user [MAC_BYTES];
  logic [2:0]  hdr_cnt;
  logic [2:0]  rd_idx;
  logic        inc_pass;
  logic        inc_drop;
  logic [47:0] mac;
  logic        promisc;
  logic        mcast_en;
  logic [47:0] dest;
  logic        s_hs;
  logic        m_hs;

  eth_mac_filter_regs #(
    .REG_AW (REG_AW),
    .REG_DW (REG_DW),
    .CNT_W  (CNT_W)
  ) u_regs (
    .clk       (clk_i),
    .rst       (rst_i),
    .reg_addr  (reg_addr),
    .reg_write (reg_write),
    .reg_wdata (reg_wdata),
    .reg_wstrb (reg_wstrb),
    .reg_valid (reg_valid),
    .reg_rdata (reg_rdata),
    .reg_error (reg_error),
    .reg_ready (reg_ready),
    .inc_pass  (inc_pass),
    .inc_drop  (inc_drop),
    .mac       (mac),
    .promisc   (promisc),
    .mcast_en  (mcast_en)
  );

  assign dbg_state = state;
  assign s_hs      = s_axis_tvalid && s_axis_tready;
  assign m_hs      = m_axis_tvalid && m_axis_tready;

  // Destination as seen on the 6th header handshake: 5 buffered bytes plus
  // the byte currently on the input.
  always_comb begin
    dest = '0;
    for (int i = 0; i < MAC_BYTES - 1; i++) dest[8*i +: 8] = hdr_data[i];
    dest[8*(MAC_BYTES-1) +: 8] = s_axis_tdata;
  end

  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tlast  = s_axis_tlast;
    m_axis_tuser  = s_axis_tuser;
    case (state)
      HDR, DROP: s_axis_tready = 1'b1;
      REPLAY: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_data[rd_idx];
        m_axis_tlast  = hdr_last[rd_idx];
        m_axis_tuser  = hdr_user[rd_idx];
      end
      PASS: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= HDR;
      hdr_cnt  <= '0;
      rd_idx   <= '0;
      inc_pass <= 1'b0;
      inc_drop <= 1'b0;
      for (int i = 0; i < MAC_BYTES; i++) begin
        hdr_data[i] <= '0;
        hdr_last[i] <= 1'b0;
        hdr_user[i] <= 1'b0;
      end
    end else begin
      inc_pass <= 1'b0;
      inc_drop <= 1'b0;
      case (state)
        HDR: begin
          if (s_hs) begin
            hdr_data[hdr_cnt] <= s_axis_tdata;
            hdr_last[hdr_cnt] <= s_axis_tlast;
            hdr_user[hdr_cnt] <= s_axis_tuser;
            if (hdr_cnt == LAST_IDX) begin
              hdr_cnt <= '0;
              if (mac_accept(dest, mac, promisc, mcast_en)) begin
                state  <= REPLAY;
                rd_idx <= '0;
              end else if (s_axis_tlast) begin
                inc_drop <= 1'b1;          // 6-byte rejected frame ends here
              end else begin
                state <= DROP;
              end
            end else if (s_axis_tlast) begin
              hdr_cnt  <= '0;              // runt frame
              inc_drop <= 1'b1;
            end else begin
              hdr_cnt <= hdr_cnt + 3'd1;
            end
          end
        end
        REPLAY: begin
          if (m_hs) begin
            if (rd_idx == LAST_IDX) begin
              if (hdr_last[LAST_IDX]) begin
                state    <= HDR;
                inc_pass <= 1'b1;
              end else begin
                state <= PASS;
              end
            end else begin
              rd_idx <= rd_idx + 3'd1;
            end
          end
        end
        PASS: begin
          if (s_hs && s_axis_tlast) begin
            state    <= HDR;
            inc_pass <= 1'b1;
          end
        end
        DROP: begin
          if (s_hs && s_axis_tlast) begin
            state    <= HDR;
            inc_drop <= 1'b1;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_axis_mac_filter.sv
// Directed testbench for eth_axis_mac_filter.
// Counter expectations follow MAC_FILTER_STATS_EN (0 when undefined).
`timescale 1ns/1ps
module tb_eth_axis_mac_filter;
  import eth_mac_filter_pkg::*;

  localparam int REG_AW = 4;
  localparam int REG_DW = 32;
  localparam int CNT_W  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]          s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic                s_axis_tlast;
  logic                s_axis_tuser;
  logic [7:0]          m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                m_axis_tlast;
  logic                m_axis_tuser;
  logic [REG_AW-1:0]   reg_addr;
  logic                reg_write;
  logic [REG_DW-1:0]   reg_wdata;
  logic [REG_DW/8-1:0] reg_wstrb;
  logic                reg_valid;
  logic [REG_DW-1:0]   reg_rdata;
  logic                reg_error;
  logic                reg_ready;
  state_t              dbg_state;

  eth_axis_mac_filter #(
    .REG_AW (REG_AW),
    .REG_DW (REG_DW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .reg_addr      (reg_addr),
    .reg_write     (reg_write),
    .reg_wdata     (reg_wdata),
    .reg_wstrb     (reg_wstrb),
    .reg_valid     (reg_valid),
    .reg_rdata     (reg_rdata),
    .reg_error     (reg_error),
    .reg_ready     (reg_ready),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] exp_q[$];           // {tuser, tlast, tdata}
  logic [7:0] frm_data [128];
  logic       frm_user [128];
  bit         stall_mode = 0;
  int         gap_max    = 0;
  bit         mon_prev_stall = 0;
  logic [9:0] mon_prev_beat  = '0;
  int         mon_stall_left = 0;
  logic [9:0] mon_beat;
  logic [9:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef MAC_FILTER_STATS_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // ---------------- output monitor ----------------
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_mode && mon_stall_left > 0) begin
        m_axis_tready = 1'b0;
        mon_stall_left--;
      end else begin
        m_axis_tready = 1'b1;
      end
      #2;
      mon_beat = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (mon_prev_stall) begin
        check("hold_valid", {31'b0, m_axis_tvalid}, 32'd1);
        check("hold_beat", {22'b0, mon_beat}, {22'b0, mon_prev_beat});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("out_valid_idle", {31'b0, m_axis_tvalid}, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("out_beat", {22'b0, mon_beat}, {22'b0, mon_exp});
        end
        if (stall_mode)
          mon_stall_left = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 50) : 0;
      end
      mon_prev_stall = m_axis_tvalid && !m_axis_tready;
      mon_prev_beat  = mon_beat;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reg_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] strb,
                        output logic err);
    reg_valid = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = d; reg_wstrb = strb;
    #2;
    err = reg_error;
    @(negedge clk);
    reg_valid = 1'b0; reg_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [31:0] d, output logic err,
                        output logic rdy);
    reg_valid = 1'b1; reg_write = 1'b0; reg_addr = a; reg_wstrb = 4'h0;
    #2;
    d = reg_rdata; err = reg_error; rdy = reg_ready;
    @(negedge clk);
    reg_valid = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    logic        r;
    reg_rd(a, d, e, r);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic e;
    reg_wr(a, d, 4'hF, e);
  endtask

  task automatic build(input logic [47:0] dest, input int len);
    for (int i = 0; i < len; i++) begin
      frm_data[i] = (i < MAC_BYTES) ? dest[47-8*i -: 8] : 8'(i * 7 + 3);
      frm_user[i] = (i == 2) || (i == len - 2);
    end
  endtask

  task automatic send_frame(input int len, input bit exp_pass, input bit lat_chk,
                            output int stalls);
    int gap;
    int t;
    stalls = 0;
    if (exp_pass)
      for (int i = 0; i < len; i++) exp_q.push_back({frm_user[i], (i == len - 1), frm_data[i]});
    for (int i = 0; i < len; i++) begin
      if (gap_max > 0) begin
        gap = $urandom_range(0, gap_max);
        repeat (gap) @(negedge clk);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = frm_data[i];
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = frm_user[i];
      t = 0;
      #2;
      while (!s_axis_tready && t < 3000) begin
        stalls++;
        @(negedge clk);
        #2;
        t++;
      end
      if (t >= 3000) check("s_tready_timeout", {31'b0, s_axis_tready}, 32'd1);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (lat_chk && i == MAC_BYTES - 1) begin
        #1;
        check("first_out_latency", {31'b0, m_axis_tvalid}, 32'd1);
        check("replay_state", {30'b0, dbg_state}, {30'b0, REPLAY});
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_counts(input string tag, input logic [31:0] p, input logic [31:0] d);
    rd_check({tag, "_pass_cnt"}, REG_PASS, exp_cnt(p));
    rd_check({tag, "_drop_cnt"}, REG_DROP, exp_cnt(d));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    logic        e;
    logic        r;
    int          stalls;

    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    reg_addr = '0; reg_write = 1'b0; reg_wdata = '0; reg_wstrb = '0; reg_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #2;

    // 1: reset state and register reads
    check("rst_m_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("rst_s_tready", {31'b0, s_axis_tready}, 32'd1);
    check("rst_state", {30'b0, dbg_state}, {30'b0, HDR});
    check("idle_reg_ready", {31'b0, reg_ready}, 32'd0);
    @(negedge clk);
    reg_rd(REG_MAC_LO, d, e, r);
    check("rst_mac_lo", d, 32'h0);
    check("rd_ready", {31'b0, r}, 32'd1);
    check("rd_error", {31'b0, e}, 32'd0);
    rd_check("rst_mac_hi", REG_MAC_HI, 32'h0);
    check_counts("rst", 32'd0, 32'd0);
    reg_rd(4'h2, d, e, r);
    check("misaligned_error", {31'b0, e}, 32'd1);
    check("misaligned_ready", {31'b0, r}, 32'd1);

    // Register access rules
    reg_wr(4'h1, 32'hFFFF_FFFF, 4'hF, e);
    check("misaligned_wr_error", {31'b0, e}, 32'd1);
    rd_check("misaligned_wr_ignored", REG_MAC_LO, 32'h0);
    wr(REG_MAC_HI, 32'hFFFF_FFFF);
    rd_check("mac_hi_reserved", REG_MAC_HI, 32'h0003_FFFF);
    wr(REG_MAC_LO, 32'h9800_1032);
    wr(REG_MAC_HI, 32'h0000_2070);
    rd_check("mac_hi_prog", REG_MAC_HI, 32'h0000_2070);
    reg_wr(REG_MAC_LO, 32'hAAAA_AAAA, 4'b0100, e);
    rd_check("wstrb_byte2", REG_MAC_LO, 32'h98AA_1032);
    wr(REG_MAC_LO, 32'h9800_1032);
    rd_check("mac_lo_prog", REG_MAC_LO, 32'h9800_1032);

    // 2: own-MAC frame passes intact
    build(48'h3210_0098_7020, 64);
    send_frame(64, 1'b1, 1'b1, stalls);
    wait_drain();
    check_counts("own", 32'd1, 32'd0);

    // 3: multicast rejected while disabled, then accepted
    build(48'h3310_0098_7020, 64);
    send_frame(64, 1'b0, 1'b0, stalls);
    check("drop_s_tready_stalls", stalls, 32'd0);
    repeat (3) @(negedge clk);
    check("drop_back_to_hdr", {30'b0, dbg_state}, {30'b0, HDR});
    check_counts("mcast_off", 32'd1, 32'd1);
    wr(REG_MAC_HI, 32'h0002_2070);
    send_frame(64, 1'b1, 1'b0, stalls);
    wait_drain();
    check_counts("mcast_on", 32'd2, 32'd1);

    // 4: broadcast always, foreign unicast in promiscuous mode
    wr(REG_MAC_HI, 32'h0000_2070);
    build(48'hFFFF_FFFF_FFFF, 40);
    send_frame(40, 1'b1, 1'b0, stalls);
    wait_drain();
    check_counts("bcast", 32'd3, 32'd1);
    wr(REG_MAC_HI, 32'h0001_2070);
    build(48'h0011_2233_4455, 20);
    send_frame(20, 1'b1, 1'b0, stalls);
    wait_drain();
    check_counts("promisc", 32'd4, 32'd1);
    wr(REG_MAC_HI, 32'h0000_2070);

    // 5: runt frame dropped, following frame intact
    build(48'h3210_0098_7020, 4);
    send_frame(4, 1'b0, 1'b0, stalls);
    repeat (3) @(negedge clk);
    check_counts("runt", 32'd4, 32'd2);
    build(48'h3210_0098_7020, 64);
    send_frame(64, 1'b1, 1'b0, stalls);
    wait_drain();
    check_counts("after_runt", 32'd5, 32'd2);

    // 6-byte frames: tlast on the decision byte
    build(48'h0200_0000_0000, 6);
    send_frame(6, 1'b0, 1'b0, stalls);
    repeat (3) @(negedge clk);
    check("six_reject_state", {30'b0, dbg_state}, {30'b0, HDR});
    check_counts("six_reject", 32'd5, 32'd3);
    build(48'h3210_0098_7020, 6);
    send_frame(6, 1'b1, 1'b0, stalls);
    wait_drain();
    check_counts("six_accept", 32'd6, 32'd3);

    // 6: input gaps and output stalls
    stall_mode = 1;
    gap_max    = 5;
    build(48'h3210_0098_7020, 64);
    send_frame(64, 1'b1, 1'b0, stalls);
    wait_drain();
    stall_mode = 0;
    gap_max    = 0;
    check_counts("stall", 32'd7, 32'd3);

    // Writing a counter clears both
    wr(REG_PASS, 32'h0);
    check_counts("clear", 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
